// File: rtl/ascii_num_pkg.sv
// Shared constants and types for the ASCII number stream parser.
package ascii_num_pkg;

  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_9     = 8'h39;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_PLUS  = 8'h2B;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_COMMA = 8'h2C;
  localparam logic [7:0] CH_TAB   = 8'h09;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;

  typedef enum logic [1:0] {CC_DIGIT, CC_SIGN, CC_SEP, CC_INVALID} char_class_t;

  typedef enum logic [1:0] {IDLE, SIGN, DIGITS} parse_state_t;

endpackage

// File: rtl/ascii_char_classify.sv
// Combinational byte classifier: digit / sign / separator / invalid.
module ascii_char_classify
  import ascii_num_pkg::*;
#(
  parameter bit ALLOW_PLUS = 1'b1
) (
  input  logic [7:0]  char_i,
  output char_class_t class_o,
  output logic [3:0]  digit_o
);

  // Decode the character class and the numeric value of digits.
  always_comb begin
    class_o = CC_INVALID;
    digit_o = '0;
    if (char_i >= CH_0 && char_i <= CH_9) begin
      class_o = CC_DIGIT;
      digit_o = 4'(char_i - CH_0);
    end else if (char_i == CH_MINUS || (ALLOW_PLUS && char_i == CH_PLUS)) begin
      class_o = CC_SIGN;
    end else if (char_i inside {CH_SPACE, CH_COMMA, CH_TAB, CH_CR, CH_LF}) begin
      class_o = CC_SEP;
    end
  end

endmodule

// File: rtl/ascii_num_stream_parser.sv
// Splits an ASCII byte stream into signed, saturating DATA_WIDTH numbers.
module ascii_num_stream_parser
  import ascii_num_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter bit          ALLOW_PLUS = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_overflow,
  output logic                  out_last,
  output logic                  err_invalid,
  output logic                  stream_done
);

  localparam int unsigned AW = DATA_WIDTH + 1;
  localparam int unsigned PW = DATA_WIDTH + 5;
  localparam logic [PW-1:0] LIM_NEG = PW'(1) << (DATA_WIDTH - 1);
  localparam logic [PW-1:0] LIM_POS = LIM_NEG - PW'(1);

  parse_state_t          state_q, state_d;
  logic [AW-1:0]         acc_q, acc_d;
  logic                  neg_q, neg_d;
  logic                  ovf_q, ovf_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_ovf_q, out_ovf_d;
  logic                  out_last_q, out_last_d;
  logic                  err_q, err_d;
  logic                  done_q, done_d;

  char_class_t           cls;
  logic [3:0]            dig;
  logic                  accept;
  logic                  emit;
  logic [PW-1:0]         step;
  logic [PW-1:0]         lim;

  ascii_char_classify #(.ALLOW_PLUS(ALLOW_PLUS)) u_classify (
    .char_i  (in_data),
    .class_o (cls),
    .digit_o (dig)
  );

  assign in_ready = !out_valid_q | out_ready;
  assign accept   = in_valid & in_ready;

  // Parse FSM, saturating accumulator and output register next-state.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    neg_d       = neg_q;
    ovf_d       = ovf_q;
    emit        = 1'b0;
    err_d       = 1'b0;
    done_d      = 1'b0;
    out_valid_d = out_valid_q & ~out_ready;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;
    out_last_d  = out_last_q;
    lim         = neg_q ? LIM_NEG : LIM_POS;
    step        = PW'(acc_q) * PW'(10) + PW'(dig);

    if (accept) begin
      case (state_q)
        IDLE: begin
          case (cls)
            CC_DIGIT: begin
              state_d = DIGITS;
              acc_d   = AW'(dig);
              neg_d   = 1'b0;
              ovf_d   = 1'b0;
            end
            CC_SIGN: begin
              state_d = SIGN;
              acc_d   = '0;
              neg_d   = (in_data == CH_MINUS);
              ovf_d   = 1'b0;
            end
            CC_SEP: begin
            end
            default: err_d = 1'b1;
          endcase
        end
        default: begin
          case (cls)
            CC_DIGIT: begin
              state_d = DIGITS;
              if (step > lim) begin
                acc_d = lim[AW-1:0];
                ovf_d = 1'b1;
              end else begin
                acc_d = step[AW-1:0];
              end
            end
            CC_SEP:  emit = 1'b1;
            default: begin
              err_d   = 1'b1;
              state_d = IDLE;
            end
          endcase
        end
      endcase

      // in_last closes whatever is still pending after this byte, so the
      // emitted value is taken from the post-update accumulator.
      if (in_last && state_d != IDLE) emit = 1'b1;
      if (emit || in_last) state_d = IDLE;
      done_d = in_last;
    end

    if (emit) begin
      out_valid_d = 1'b1;
      out_data_d  = neg_d ? (DATA_WIDTH'(0) - acc_d[DATA_WIDTH-1:0])
                          : acc_d[DATA_WIDTH-1:0];
      out_ovf_d   = ovf_d;
      out_last_d  = in_last;
    end

    if (state_d == IDLE) begin
      acc_d = '0;
      neg_d = 1'b0;
      ovf_d = 1'b0;
    end
  end

  // State and output registers; clear acts as a synchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      neg_q       <= 1'b0;
      ovf_q       <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
    end else if (clear) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      neg_q       <= 1'b0;
      ovf_q       <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      neg_q       <= neg_d;
      ovf_q       <= ovf_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_ovf_q   <= out_ovf_d;
      out_last_q  <= out_last_d;
      err_q       <= err_d;
      done_q      <= done_d;
    end
  end

  assign out_data     = out_data_q;
  assign out_valid    = out_valid_q;
  assign out_overflow = out_ovf_q;
  assign out_last     = out_last_q;
  assign err_invalid  = err_q;
  assign stream_done  = done_q;

endmodule

// File: tb/tb_ascii_num_stream_parser.sv
// Bench: table vectors, hand-written stall/clear sequences and random
// streams checked against a token-level reference model.
module tb_ascii_num_stream_parser;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic       a_clear, a_iv, a_ir, a_il, a_ov, a_ordy, a_oovf, a_olast, a_err, a_done;
  logic [7:0] a_id;
  logic [31:0] a_od;
  logic       b_clear, b_iv, b_ir, b_il, b_ov, b_ordy, b_oovf, b_olast, b_err, b_done;
  logic [7:0] b_id;
  logic [15:0] b_od;

  ascii_num_stream_parser #(.DATA_WIDTH(32), .ALLOW_PLUS(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .clear(a_clear), .in_data(a_id), .in_valid(a_iv),
    .in_ready(a_ir), .in_last(a_il), .out_data(a_od), .out_valid(a_ov),
    .out_ready(a_ordy), .out_overflow(a_oovf), .out_last(a_olast),
    .err_invalid(a_err), .stream_done(a_done));

  ascii_num_stream_parser #(.DATA_WIDTH(16), .ALLOW_PLUS(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .clear(b_clear), .in_data(b_id), .in_valid(b_iv),
    .in_ready(b_ir), .in_last(b_il), .out_data(b_od), .out_valid(b_ov),
    .out_ready(b_ordy), .out_overflow(b_oovf), .out_last(b_olast),
    .err_invalid(b_err), .stream_done(b_done));

  typedef struct packed {
    logic [31:0] v;
    logic        ovf;
    logic        lst;
  } out_t;

  typedef struct packed {
    logic [255:0]     txt;
    int               len;
    bit               sel;
    bit               lastend;
    int               nout;
    logic [3:0][31:0] v;
    logic [3:0]       ovf;
    logic [3:0]       lst;
    int               errs;
    int               dones;
  } vec_t;

  vec_t tbl[5];

  out_t got_a[$], got_b[$], exp_a[$], exp_b[$];
  int   n_err_a = 0, n_err_b = 0, n_done_a = 0, n_done_b = 0;
  int   bg_a, bg_b, be_a, be_b, bd_a, bd_b;
  int   ncmp = 0, nfail = 0;

  bit     m_pend[2];
  bit     m_neg[2];
  longint m_mag[2];
  int     m_err[2];
  int     m_done[2];

  // Monitor: record handshakes and pulses away from the active edge.
  always @(negedge clk) begin
    if (a_ov && a_ordy) got_a.push_back({a_od, a_oovf, a_olast});
    if (b_ov && b_ordy) got_b.push_back({{16{b_od[15]}}, b_od, b_oovf, b_olast});
    if (a_err)  n_err_a++;
    if (b_err)  n_err_b++;
    if (a_done) n_done_a++;
    if (b_done) n_done_b++;
  end

  task automatic chk(string nm, longint act, longint exp);
    ncmp++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Reference model: a number is a pending token; saturation is decided
  // once at the end from the exact (clamped) magnitude.
  task automatic model_emit(bit sel, bit last);
    int     w   = sel ? 16 : 32;
    longint lim = m_neg[sel] ? (longint'(1) << (w - 1)) : ((longint'(1) << (w - 1)) - 1);
    bit     o   = m_mag[sel] > lim;
    longint m   = o ? lim : m_mag[sel];
    longint val = m_neg[sel] ? -m : m;
    out_t   r;
    r.v = val[31:0];
    r.ovf = o;
    r.lst = last;
    if (sel) exp_b.push_back(r); else exp_a.push_back(r);
    m_pend[sel] = 1'b0;
  endtask

  task automatic model_byte(bit sel, logic [7:0] c, bit last);
    if (c >= 8'h30 && c <= 8'h39) begin
      if (!m_pend[sel]) begin
        m_pend[sel] = 1'b1;
        m_neg[sel]  = 1'b0;
        m_mag[sel]  = 0;
      end
      m_mag[sel] = m_mag[sel] * 10 + longint'(c - 8'h30);
      if (m_mag[sel] > (longint'(1) << 40)) m_mag[sel] = longint'(1) << 40;
    end else if (c == 8'h2D || (c == 8'h2B && !sel)) begin
      if (m_pend[sel]) begin
        m_err[sel]++;
        m_pend[sel] = 1'b0;
      end else begin
        m_pend[sel] = 1'b1;
        m_neg[sel]  = (c == 8'h2D);
        m_mag[sel]  = 0;
      end
    end else if (c inside {8'h20, 8'h2C, 8'h09, 8'h0D, 8'h0A}) begin
      if (m_pend[sel]) model_emit(sel, last);
    end else begin
      m_err[sel]++;
      m_pend[sel] = 1'b0;
    end
    if (last) begin
      if (m_pend[sel]) model_emit(sel, 1'b1);
      m_done[sel]++;
    end
  endtask

  task automatic mark(bit sel);
    if (sel) begin
      bg_a = bg_a; bg_b = got_b.size(); be_b = n_err_b; bd_b = n_done_b; exp_b.delete();
    end else begin
      bg_a = got_a.size(); be_a = n_err_a; bd_a = n_done_a; exp_a.delete();
    end
    m_pend[sel] = 1'b0;
    m_err[sel]  = 0;
    m_done[sel] = 0;
  endtask

  task automatic send(bit sel, logic [7:0] c, bit last);
    bit ok = 1'b0;
    if (sel) begin b_id = c; b_iv = 1'b1; b_il = last; end
    else     begin a_id = c; a_iv = 1'b1; a_il = last; end
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (sel ? b_ir : a_ir) ok = 1'b1;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    if (sel) begin b_iv = 1'b0; b_il = 1'b0; end
    else     begin a_iv = 1'b0; a_il = 1'b0; end
    if (!ok) chk("send_timeout", 0, 1);
    else model_byte(sel, c, last);
  endtask

  task automatic compare_sb(bit sel, string tag);
    int   ng, ne;
    out_t g, e;
    if (sel) b_ordy = 1'b1; else a_ordy = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    ng = sel ? got_b.size() - bg_b : got_a.size() - bg_a;
    ne = sel ? exp_b.size() : exp_a.size();
    chk({tag, "_count"}, ng, ne);
    for (int i = 0; i < ne && i < ng; i++) begin
      g = sel ? got_b[bg_b + i] : got_a[bg_a + i];
      e = sel ? exp_b[i] : exp_a[i];
      chk($sformatf("%s_data%0d", tag, i), g.v, e.v);
      chk($sformatf("%s_ovf%0d", tag, i), g.ovf, e.ovf);
      chk($sformatf("%s_last%0d", tag, i), g.lst, e.lst);
    end
    chk({tag, "_err"},  sel ? n_err_b - be_b : n_err_a - be_a, m_err[sel]);
    chk({tag, "_done"}, sel ? n_done_b - bd_b : n_done_a - bd_a, m_done[sel]);
  endtask

  task automatic run_vec(int idx, vec_t t);
    int   ng;
    out_t g;
    if (t.sel) b_ordy = 1'b1; else a_ordy = 1'b1;
    mark(t.sel);
    for (int i = 0; i < t.len; i++)
      send(t.sel, t.txt[8*(t.len-1-i) +: 8], t.lastend && (i == t.len - 1));
    repeat (4) @(posedge clk);
    #1;
    ng = t.sel ? got_b.size() - bg_b : got_a.size() - bg_a;
    chk($sformatf("vec%0d_count", idx), ng, t.nout);
    for (int i = 0; i < t.nout && i < ng; i++) begin
      g = t.sel ? got_b[bg_b + i] : got_a[bg_a + i];
      chk($sformatf("vec%0d_data%0d", idx, i), g.v, t.v[i]);
      chk($sformatf("vec%0d_ovf%0d", idx, i), g.ovf, t.ovf[i]);
      chk($sformatf("vec%0d_last%0d", idx, i), g.lst, t.lst[i]);
    end
    chk($sformatf("vec%0d_err", idx),  t.sel ? n_err_b - be_b : n_err_a - be_a, t.errs);
    chk($sformatf("vec%0d_done", idx), t.sel ? n_done_b - bd_b : n_done_a - bd_a, t.dones);
  endtask

  function automatic logic [7:0] pick();
    int unsigned r = $urandom % 32;
    if (r < 20) return 8'h30 + 8'(r % 10);
    case (r)
      20: return 8'h2D;
      21: return 8'h2B;
      22: return 8'h20;
      23: return 8'h2C;
      24: return 8'h0A;
      25: return 8'h09;
      26: return 8'h0D;
      27: return 8'h78;
      28: return 8'h2E;
      default: return 8'h20;
    endcase
  endfunction

  task automatic rand_run(bit sel, int n);
    bit stop = 1'b0;
    mark(sel);
    fork
      begin
        for (int k = 0; k < n; k++) send(sel, pick(), ($urandom % 20) == 0);
        stop = 1'b1;
      end
      begin
        while (!stop) begin
          @(posedge clk);
          #1;
          if (sel) b_ordy = ($urandom % 3) != 0;
          else     a_ordy = ($urandom % 3) != 0;
        end
      end
    join
    compare_sb(sel, sel ? "rndB" : "rndA");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{txt: "12 -34,0042\n", len: 12, sel: 1'b0, lastend: 1'b0, nout: 3,
               v: {32'd0, 32'd42, 32'hFFFF_FFDE, 32'd12}, ovf: 4'b0000, lst: 4'b0000,
               errs: 0, dones: 0};
    tbl[1] = '{txt: "2147483647 -2147483648", len: 22, sel: 1'b0, lastend: 1'b1, nout: 2,
               v: {32'd0, 32'd0, 32'h8000_0000, 32'h7FFF_FFFF}, ovf: 4'b0000, lst: 4'b0010,
               errs: 0, dones: 1};
    tbl[2] = '{txt: "2147483648 -99999999999,", len: 24, sel: 1'b0, lastend: 1'b0, nout: 2,
               v: {32'd0, 32'd0, 32'h8000_0000, 32'h7FFF_FFFF}, ovf: 4'b0011, lst: 4'b0000,
               errs: 0, dones: 0};
    tbl[3] = '{txt: "-, 1x2 5", len: 8, sel: 1'b0, lastend: 1'b1, nout: 3,
               v: {32'd0, 32'd5, 32'd2, 32'd0}, ovf: 4'b0000, lst: 4'b0100,
               errs: 1, dones: 1};
    tbl[4] = '{txt: "32768 +5 -32768 ", len: 16, sel: 1'b1, lastend: 1'b0, nout: 3,
               v: {32'd0, 32'hFFFF_8000, 32'd5, 32'd32767}, ovf: 4'b0001, lst: 4'b0000,
               errs: 1, dones: 0};

    rst_n = 1'b0;
    a_clear = 1'b0; a_iv = 1'b0; a_il = 1'b0; a_id = '0; a_ordy = 1'b0;
    b_clear = 1'b0; b_iv = 1'b0; b_il = 1'b0; b_id = '0; b_ordy = 1'b0;
    bg_a = 0; bg_b = 0; be_a = 0; be_b = 0; bd_a = 0; bd_b = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_a_out_valid", a_ov, 0);
    chk("rst_a_out_data", a_od, 0);
    chk("rst_a_err", a_err, 0);
    chk("rst_a_done", a_done, 0);
    chk("rst_a_in_ready", a_ir, 1);
    chk("rst_b_out_valid", b_ov, 0);
    chk("rst_b_out_data", b_od, 0);
    chk("rst_b_in_ready", b_ir, 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    for (int t = 0; t < 5; t++) run_vec(t, tbl[t]);

    // Output stall: in_ready must drop while 7 waits, then 7/8/9 drain in order.
    mark(1'b0);
    a_ordy = 1'b0;
    fork
      begin
        send(1'b0, 8'h37, 1'b0); send(1'b0, 8'h20, 1'b0);
        send(1'b0, 8'h38, 1'b0); send(1'b0, 8'h20, 1'b0);
        send(1'b0, 8'h39, 1'b0); send(1'b0, 8'h20, 1'b0);
      end
      begin
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("stall_in_ready", a_ir, 0);
        chk("stall_out_valid", a_ov, 1);
        chk("stall_out_data", a_od, 7);
        repeat (10) @(posedge clk);
        #1 a_ordy = 1'b1;
      end
    join
    compare_sb(1'b0, "stall");
    chk("stall_total", got_a.size() - bg_a, 3);

    // Clear mid-number: "12" is abandoned, "3" afterwards parses normally.
    mark(1'b1);
    b_ordy = 1'b1;
    send(1'b1, 8'h31, 1'b0);
    send(1'b1, 8'h32, 1'b0);
    b_clear = 1'b1;
    @(posedge clk);
    #1 b_clear = 1'b0;
    m_pend[1] = 1'b0;
    send(1'b1, 8'h20, 1'b0);
    send(1'b1, 8'h33, 1'b0);
    send(1'b1, 8'h20, 1'b0);
    compare_sb(1'b1, "clr");
    chk("clr_total", got_b.size() - bg_b, 1);

    // Clear while a result is held: it is dropped, never delivered.
    mark(1'b1);
    b_ordy = 1'b0;
    send(1'b1, 8'h34, 1'b0);
    send(1'b1, 8'h20, 1'b0);
    @(negedge clk);
    chk("clrhold_valid_before", b_ov, 1);
    @(posedge clk);
    #1 b_clear = 1'b1;
    @(posedge clk);
    #1 b_clear = 1'b0;
    @(negedge clk);
    chk("clrhold_valid_after", b_ov, 0);
    chk("clrhold_data_after", b_od, 0);
    @(posedge clk);
    #1 b_ordy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("clrhold_total", got_b.size() - bg_b, 0);

    rand_run(1'b0, 400);
    rand_run(1'b1, 400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
